// File: rtl/polar_clip_dlk_pkg.sv
// Shared types and defaults for the deadlock reporter: FSM encoding, default
// parameters and a helper that sizes the persistence counters.
package polar_clip_dlk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SUSPECT  = 2'd1,
    ST_DEADLOCK = 2'd2,
    ST_UNUSED   = 2'd3
  } dlk_state_e;

  localparam int unsigned DEF_THRESHOLD = 1024;
  localparam int unsigned DEF_STAMP_W   = 32;

  // Bits needed to hold the values 0..threshold inclusive.
  function automatic int unsigned cnt_width(input int unsigned threshold);
    return $clog2(threshold + 1);
  endfunction

endpackage

// File: rtl/polar_clip_dlk_persist_cnt.sv
// Per-channel persistence counter: counts consecutive blocked cycles and
// saturates at THRESHOLD, where the channel is reported as stuck.
module polar_clip_dlk_persist_cnt
  import polar_clip_dlk_pkg::*;
#(
  parameter int unsigned THRESHOLD = DEF_THRESHOLD
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic block_i,
  output logic stuck_o
);

  localparam int unsigned CW = cnt_width(THRESHOLD);
  localparam logic [CW-1:0] THR = CW'(THRESHOLD);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !block_i) begin
      cnt_d = '0;
    end else if (cnt_q != THR) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stuck_o = (cnt_q == THR);

endmodule

// File: rtl/polar_clip_deadlock_reporter.sv
// Aggregates per-channel block indications into a latched deadlock report
// with a one-cycle irq, a mask of stuck channels and a cycle timestamp.
module polar_clip_deadlock_reporter
  import polar_clip_dlk_pkg::*;
#(
  parameter int unsigned NUM_MON   = 2,
  parameter int unsigned THRESHOLD = DEF_THRESHOLD,
  parameter int unsigned STAMP_W   = DEF_STAMP_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_MON-1:0] block_in,
  input  logic               clear,
  output logic               deadlock,
  output logic               irq,
  output logic [NUM_MON-1:0] deadlock_mask,
  output logic [STAMP_W-1:0] deadlock_stamp,
  output logic [1:0]         state_o
);

  dlk_state_e         state_q, state_d;
  logic [STAMP_W-1:0] cyc_q, cyc_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [NUM_MON-1:0] mask_q, mask_d;
  logic               irq_q, irq_d;
  logic [NUM_MON-1:0] stuck_mask;
  logic               cnt_clr;

  // clear and enable=0 both wipe partial counts in every state.
  assign cnt_clr = clear || !enable;

  for (genvar gi = 0; gi < NUM_MON; gi++) begin : g_persist
    polar_clip_dlk_persist_cnt #(
      .THRESHOLD(THRESHOLD)
    ) u_cnt (
      .clock  (clock),
      .reset  (reset),
      .clr_i  (cnt_clr),
      .block_i(block_in[gi]),
      .stuck_o(stuck_mask[gi])
    );
  end

  assign cyc_d = (&cyc_q) ? cyc_q : cyc_q + STAMP_W'(1);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    stamp_d = stamp_q;
    irq_d   = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_SUSPECT: begin
          // clear wins over a detection landing on the same edge
          if (clear) begin
            state_d = ST_IDLE;
          end else if (|stuck_mask) begin
            state_d = ST_DEADLOCK;
            mask_d  = stuck_mask;
            stamp_d = cyc_q;
            irq_d   = 1'b1;
          end else if (|block_in) begin
            state_d = ST_SUSPECT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DEADLOCK: begin
          if (clear) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      stamp_q <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stamp_q <= stamp_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
    end
  end

  assign deadlock       = (state_q == ST_DEADLOCK);
  assign irq            = irq_q;
  assign deadlock_mask  = mask_q;
  assign deadlock_stamp = stamp_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_polar_clip_deadlock_reporter.sv
// Scoreboard bench: a behavioural model predicts each cycle's outputs into a
// queue, which is popped and compared after every clock edge.
module tb_polar_clip_deadlock_reporter;

  localparam int THR = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  block_in;
  logic        clear;
  logic        deadlock;
  logic        irq;
  logic [1:0]  deadlock_mask;
  logic [31:0] deadlock_stamp;
  logic [1:0]  state_o;

  polar_clip_deadlock_reporter #(
    .NUM_MON  (2),
    .THRESHOLD(THR),
    .STAMP_W  (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .block_in      (block_in),
    .clear         (clear),
    .deadlock      (deadlock),
    .irq           (irq),
    .deadlock_mask (deadlock_mask),
    .deadlock_stamp(deadlock_stamp),
    .state_o       (state_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        dl;
    logic        irq;
    logic [1:0]  mask;
    logic [31:0] stamp;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          irq_seen = 0;
  int          m_cnt[2];
  logic [1:0]  m_st;
  logic [1:0]  m_mask;
  logic [31:0] m_stamp;
  logic [31:0] m_cyc;
  logic        m_irq;
  logic [1:0]  saved_mask;
  logic [31:0] saved_stamp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_st     = 2'd0;
    m_mask   = 2'b00;
    m_stamp  = 32'd0;
    m_cyc    = 32'd0;
    m_irq    = 1'b0;
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic predict();
    logic [1:0] stuck;
    int         n_cnt[2];
    exp_t       e;
    for (int i = 0; i < 2; i++) begin
      stuck[i] = (m_cnt[i] == THR);
      if (!enable || clear || !block_in[i]) n_cnt[i] = 0;
      else if (m_cnt[i] < THR)              n_cnt[i] = m_cnt[i] + 1;
      else                                  n_cnt[i] = m_cnt[i];
    end
    m_irq = 1'b0;
    if (!enable) begin
      m_st = 2'd0;
    end else if (m_st == 2'd2) begin
      if (clear) m_st = 2'd0;
    end else if (clear) begin
      m_st = 2'd0;
    end else if (stuck != 2'b00) begin
      m_st    = 2'd2;
      m_mask  = stuck;
      m_stamp = m_cyc;
      m_irq   = 1'b1;
    end else begin
      m_st = (block_in != 2'b00) ? 2'd1 : 2'd0;
    end
    m_cnt[0] = n_cnt[0];
    m_cnt[1] = n_cnt[1];
    if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
    e.dl    = (m_st == 2'd2);
    e.irq   = m_irq;
    e.mask  = m_mask;
    e.stamp = m_stamp;
    e.st    = m_st;
    exp_q.push_back(e);
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic step();
    exp_t e;
    predict();
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk("sb_deadlock", 64'(deadlock), 64'(e.dl));
    chk("sb_irq", 64'(irq), 64'(e.irq));
    chk("sb_mask", 64'(deadlock_mask), 64'(e.mask));
    chk("sb_stamp", 64'(deadlock_stamp), 64'(e.stamp));
    chk("sb_state", 64'(state_o), 64'(e.st));
    if (irq) irq_seen++;
    $display("t=%0t blk=%b clr=%b en=%b -> st=%0d dl=%b irq=%b mask=%b stamp=%0d",
             $time, block_in, clear, enable, state_o, deadlock, irq, deadlock_mask, deadlock_stamp);
    @(negedge clock);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    block_in = 2'b00;
    clear    = 1'b0;
    model_reset();
    @(negedge clock);
    chk("rst_deadlock", 64'(deadlock), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_stamp", 64'(deadlock_stamp), 64'd0);
    reset = 1'b0;

    // Single channel held from cycle 10: detection on the 9th held edge.
    steps(10);
    block_in = 2'b01;
    steps(8);
    chk("s1_no_dl_edge8", 64'(deadlock), 64'd0);
    chk("s1_suspect", 64'(state_o), 64'd1);
    step();
    chk("s1_dl_edge9", 64'(deadlock), 64'd1);
    chk("s1_irq", 64'(irq), 64'd1);
    chk("s1_mask", 64'(deadlock_mask), 64'd1);
    chk("s1_stamp", 64'(deadlock_stamp), 64'd18);
    step();
    chk("s1_irq_one_cycle", 64'(irq), 64'd0);
    block_in = 2'b00;
    steps(3);
    chk("s1_hold_dl", 64'(deadlock), 64'd1);
    chk("s1_hold_stamp", 64'(deadlock_stamp), 64'd18);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("s1_clear_idle", 64'(state_o), 64'd0);

    // 7 high, 1 low gap, 7 high: never reaches threshold.
    irq_seen = 0;
    block_in = 2'b01;
    steps(7);
    block_in = 2'b00;
    step();
    chk("s2_gap_idle", 64'(state_o), 64'd0);
    block_in = 2'b01;
    steps(7);
    block_in = 2'b00;
    step();
    chk("s2_no_irq", 64'(irq_seen), 64'd0);

    // Both channels together, then clear and re-detect.
    irq_seen = 0;
    block_in = 2'b11;
    steps(9);
    chk("s3_mask", 64'(deadlock_mask), 64'd3);
    steps(3);
    chk("s3_single_irq", 64'(irq_seen), 64'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("s3_clear_idle", 64'(state_o), 64'd0);
    steps(8);
    chk("s3_no_redetect_early", 64'(deadlock), 64'd0);
    step();
    chk("s3_redetect", 64'(deadlock), 64'd1);
    saved_mask  = deadlock_mask;
    saved_stamp = deadlock_stamp;
    clear = 1'b1;
    block_in = 2'b00;
    step();
    clear = 1'b0;

    // clear lands on the detection edge.
    irq_seen = 0;
    block_in = 2'b01;
    steps(8);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("s4_idle", 64'(state_o), 64'd0);
    chk("s4_no_irq", 64'(irq_seen), 64'd0);
    chk("s4_mask_kept", 64'(deadlock_mask), 64'(saved_mask));
    chk("s4_stamp_kept", 64'(deadlock_stamp), 64'(saved_stamp));
    block_in = 2'b00;
    step();

    // enable drop during SUSPECT.
    block_in = 2'b01;
    steps(3);
    enable = 1'b0;
    step();
    chk("s6_en_idle", 64'(state_o), 64'd0);
    enable = 1'b1;
    steps(8);
    chk("s6_no_dl_early", 64'(deadlock), 64'd0);
    step();
    chk("s6_dl", 64'(deadlock), 64'd1);

    // Asynchronous reset while in DEADLOCK, between edges.
    #1 reset = 1'b1;
    #1;
    chk("s5_rst_deadlock", 64'(deadlock), 64'd0);
    chk("s5_rst_irq", 64'(irq), 64'd0);
    chk("s5_rst_mask", 64'(deadlock_mask), 64'd0);
    chk("s5_rst_stamp", 64'(deadlock_stamp), 64'd0);
    chk("s5_rst_state", 64'(state_o), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    steps(9);
    chk("s5_post_dl", 64'(deadlock), 64'd1);
    chk("s5_post_stamp", 64'(deadlock_stamp), 64'd8);
    clear = 1'b1;
    step();

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      block_in[0] = ($urandom_range(0, 9) < 9);
      block_in[1] = ($urandom_range(0, 9) < 8);
      clear       = ($urandom_range(0, 39) == 0);
      enable      = ($urandom_range(0, 59) != 0);
      step();
    end

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/polar_clip_deadlock_reporter.md
POLAR_CLIP_DEADLOCK_REPORTER -- requirements
Module: polar_clip_deadlock_reporter

Interface
REQ-001 Parameter NUM_MON, default 2, number of per-instance deadlock monitor `block` outputs consumed.
REQ-002 Parameter THRESHOLD, default 1024, number of consecutive blocked cycles that declares a deadlock; legal range 2..65535.
REQ-003 Parameter STAMP_W, default 32, width of the free-running cycle counter and of the latched timestamp.
REQ-004 clock  input  1  single clock for all logic.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  1 = monitoring active; 0 = counters held at zero and FSM forced to IDLE.
REQ-007 block_in  input  NUM_MON  registered `block` outputs of the upstream deadlock monitors, same clock domain.
REQ-008 clear  input  1  level; releases a latched deadlock.
REQ-009 deadlock  output  1  high while in DEADLOCK state.
REQ-010 irq  output  1  one-cycle pulse on entry to DEADLOCK.
REQ-011 deadlock_mask  output  NUM_MON  channels stuck at the moment of detection.
REQ-012 deadlock_stamp  output  STAMP_W  cycle counter value at the moment of detection.
REQ-013 state_o  output  2  current FSM state encoding, for debug.

Function
REQ-014 Free-running cycle counter shall increment every cycle after reset and saturate at all-ones (no wrap).
REQ-015 Per channel i, a persistence counter shall increment when enable=1 and block_in[i]=1, clear to 0 when block_in[i]=0, and saturate at THRESHOLD.
REQ-016 Channel i shall be "stuck" (stuck_mask[i]=1) when its counter equals THRESHOLD.
REQ-017 FSM states: IDLE=0 (no channel blocked), SUSPECT=1 (at least one counter nonzero, none stuck), DEADLOCK=2; encoding 3 unused and shall recover to IDLE.
REQ-018 IDLE->SUSPECT when any block_in bit is 1 and enable=1; SUSPECT->IDLE when all block_in bits are 0.
REQ-019 IDLE or SUSPECT->DEADLOCK on the edge where stuck_mask != 0; deadlock is therefore high after edge THRESHOLD+1 counted from the first edge sampling block_in high.
REQ-020 On that transition edge, deadlock_mask <= stuck_mask, deadlock_stamp <= cycle counter, and irq <= 1 for exactly one cycle.
REQ-021 In DEADLOCK, mask, stamp and deadlock shall hold regardless of block_in (blocked channels clearing does not exit).
REQ-022 DEADLOCK->IDLE on the edge where clear=1; all persistence counters zero on the same edge; mask and stamp retain last values.
REQ-023 clear=1 in IDLE or SUSPECT shall zero all persistence counters and force IDLE; clear takes priority over a simultaneous stuck detection (no irq).
REQ-024 enable=0 shall override all except reset: counters zero, FSM to IDLE (including from DEADLOCK), irq 0; cycle counter keeps running.
REQ-025 Multiple channels reaching THRESHOLD on the same edge shall all appear in deadlock_mask.

Reset
REQ-026 On reset assertion all outputs, counters and the FSM shall go immediately to zero/IDLE without a clock edge.
REQ-027 Reset asserted mid-SUSPECT or in DEADLOCK shall discard all partial counts and latched report.
REQ-028 First counting edge is the first rising clock edge after reset deasserts.

Structure
REQ-029 Shared package polar_clip_dlk_pkg shall hold the FSM state type/encodings and default THRESHOLD/STAMP_W constants.
REQ-030 Per-channel saturating persistence counter shall be sub-module polar_clip_dlk_persist_cnt, instantiated NUM_MON times via generate.

Verification (bench uses THRESHOLD=8, NUM_MON=2)
REQ-031 block_in=2'b01 held from cycle 10 -> deadlock=1, irq pulse, mask=2'b01 after edge 9 of holding; stamp=cycle counter value at that edge.
REQ-032 block_in[0] high 7 cycles, low 1, high 7 -> no deadlock, FSM returns to IDLE during the gap, irq never asserts.
REQ-033 Both bits rise together and hold -> mask=2'b11 with single irq pulse; then clear=1 one cycle -> IDLE, counters 0, re-detect after another 9 cycles.
REQ-034 clear=1 on the same edge stuck_mask becomes nonzero -> stays IDLE, no irq, mask/stamp unchanged.
REQ-035 Reset pulsed asynchronously between clock edges while in DEADLOCK -> deadlock, irq, mask, stamp, state_o read 0 before the next edge.
REQ-036 enable=0 during SUSPECT with block_in held -> IDLE, counters 0; enable back to 1 -> detection 9 edges later.
